branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Parametrised successor to the pipeline's combinational branch decision.
- Combines a direct-mapped branch history table (BHT) and a small tagged branch target buffer (BTB).
- IF stage: predicts taken/target for the fetch PC.
- EX stage: resolves the branch from the comparator relation, flags mispredicts, supplies the redirect PC, and trains the tables on the next clock edge.

Parameters:
- ENTRIES, 64, number of BHT/BTB entries; power of two, minimum 4.
- PC_W, 32, PC and target width.
- CNT_W, 2, saturating counter width; minimum 1.
- STAT_W, 32, width of the statistics counters.

Ports:
- i_clk  in  1  system clock; all state updates on the rising edge.
- i_rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of i_clk.
- i_if_pc  in  PC_W  fetch PC.
- o_pred_taken  out  1  prediction for i_if_pc.
- o_pred_target  out  PC_W  predicted target; valid only when o_pred_taken=1.
- i_ex_valid  in  1  EX stage holds a real instruction (not a bubble or stall).
- i_ex_branch  in  3  branch type: 000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bltz, 110 bgez (new), 111 reserved.
- i_ex_relation  in  2  comparator result: 00 <, 01 =, 10 >; 11 illegal.
- i_ex_pc  in  PC_W  PC of the EX instruction.
- i_ex_target  in  PC_W  computed branch target.
- i_ex_pred_taken  in  1  prediction carried down the pipeline with this instruction.
- o_ex_taken  out  1  resolved outcome.
- o_mispredict  out  1  flush request.
- o_redirect_pc  out  PC_W  correct next PC when o_mispredict=1.
- o_branch_cnt  out  STAT_W  resolved branches since reset.
- o_miss_cnt  out  STAT_W  mispredicts since reset.

Behaviour:
- IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2].
- Per entry: valid bit, tag, CNT_W counter, target.
- Lookup is combinational, zero latency:
  - hit = valid && tag match.
  - o_pred_taken = hit && counter MSB.
  - o_pred_target = stored target.
  - On a miss, o_pred_taken=0 and o_pred_target=0.
- Resolution is combinational. is_br = i_ex_valid && i_ex_branch in {001..110}. o_ex_taken is asserted for:
  - beq: rel==01
  - bne: rel!=01
  - blez: rel!=10
  - bgtz: rel==10
  - bltz: rel==00
  - bgez: rel!=00
  - otherwise 0.
  - rel==11 is treated as "not equal / not less / not greater"; the resulting values follow from these rules and are not special-cased.
- o_mispredict = is_br && (o_ex_taken != i_ex_pred_taken).
- o_redirect_pc = o_ex_taken ? i_ex_target : i_ex_pc+4, wrapping mod 2^PC_W. Output regardless of o_mispredict.
- Non-branch with i_ex_pred_taken=1 (stale alias): o_mispredict=0, no update. Decode guarantees that fetch down the wrong path is already squashed.
- Update on the next edge when is_br:
  - Entry at the EX index: valid<=1, tag<=EX tag.
  - target<=i_ex_target, only if o_ex_taken.
  - If the previous entry was invalid or the tag differed: counter <= taken ? weakly-taken (100..0) : weakly-not-taken (011..1).
  - Otherwise: counter increments when taken, decrements when not taken, saturating at all-ones and zero.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (no bypass).
- Statistics:
  - o_branch_cnt += 1 when is_br.
  - o_miss_cnt += 1 when o_mispredict.
  - Both saturate at all-ones.
- Reset (i_rst_n=0 at an edge):
  - All valid bits, counters (to weakly-not-taken), targets, and statistics cleared in that single cycle.
  - Predictions are 0 combinationally while the array is invalid.
  - An update presented in the reset cycle is discarded; reset dominates.
- Outputs after reset: o_pred_taken=0, o_pred_target=0, o_branch_cnt=0, o_miss_cnt=0.
- o_ex_taken, o_mispredict and o_redirect_pc are pure functions of the EX inputs.

Decomposition:
- Shared package:
  - branch type codes BR_NONE..BR_BGEZ;
  - relation codes REL_LT/REL_EQ/REL_GT;
  - counter reset constants.
- One natural sub-module, branch_resolve: purely combinational branch type + relation -> taken. It supersedes the existing decision logic and adds bgez.
- Table, update and statistics logic stay in the top level.

Test Plan:
- Reset, then i_if_pc=0x0040_0010 -> o_pred_taken=0, o_pred_target=0, both counters 0.
- beq at 0x0040_0010, rel=01, pred=0, target 0x0040_0100:
  - o_ex_taken=1, o_mispredict=1, o_redirect_pc=0x0040_0100.
  - Next cycle lookup at 0x0040_0010 -> taken, target 0x0040_0100.
  - o_miss_cnt=1.
- Same bne at 0x0040_0020 resolved not-taken 3 times, then taken once (ENTRIES=64, CNT_W=2):
  - Counter path 01->00->00 (saturated)->01; prediction not-taken throughout.
  - Last resolution gives o_redirect_pc=target.
- Alias: PCs 0x0040_0010 and 0x0040_0110 share an index. A taken branch at the first, then lookup of the second -> tag miss, predict 0. Training the second replaces the entry; lookup of the first then misses.
- Same-cycle update and lookup of the same index: lookup shows the old state. Next cycle shows the new state. bgez with rel=10 -> taken; with rel=00 -> not taken, o_redirect_pc=pc+4.
- i_rst_n=0 coinciding with a mispredicting update:
  - Afterwards all lookups miss and statistics are 0.
  - i_ex_valid=0 with a beq pattern present -> no mispredict, counters unchanged.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared encodings for the branch predictor: branch types, comparator relations
// and the saturating-counter reset points.
// Latency: n/a (types and constants only). Backpressure: n/a.
package branch_predict_unit_pkg;

  // Branch type carried in the EX stage. 3'b111 is reserved and never resolves taken.
  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLEZ = 3'b011,
    BR_BGTZ = 3'b100,
    BR_BLTZ = 3'b101,
    BR_BGEZ = 3'b110,
    BR_RSVD = 3'b111
  } br_type_e;

  // Comparator relation. 2'b11 is illegal; it behaves as "not equal, not less,
  // not greater" in the resolver simply because it matches none of the codes.
  typedef enum logic [1:0] {
    REL_LT  = 2'b00,
    REL_EQ  = 2'b01,
    REL_GT  = 2'b10,
    REL_ILL = 2'b11
  } rel_e;

  // Weakly-taken is 100..0, weakly-not-taken is 011..1, for a w-bit counter.
  function automatic int unsigned cnt_weak_taken(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

  function automatic int unsigned cnt_weak_not_taken(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/branch_predict_unit_resolve.sv
// Branch resolver: branch type + comparator relation -> taken.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs.
// Ports: i_br (branch type), i_rel (relation), o_taken (resolved outcome).
module branch_resolve
  import branch_predict_unit_pkg::*;
(
  input  logic [2:0] i_br,
  input  logic [1:0] i_rel,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_br)
      BR_BEQ:  o_taken = (i_rel == REL_EQ);
      BR_BNE:  o_taken = (i_rel != REL_EQ);
      BR_BLEZ: o_taken = (i_rel != REL_GT);
      BR_BGTZ: o_taken = (i_rel == REL_GT);
      BR_BLTZ: o_taken = (i_rel == REL_LT);
      BR_BGEZ: o_taken = (i_rel != REL_LT);
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped BHT + tagged BTB, IF-stage lookup, EX-stage resolve/train.
// Latency: lookup and resolution combinational; table/statistics update on the next edge.
// Backpressure: none; an EX slot trains only when i_ex_valid marks a real branch.
// Ports: i_clk/i_rst_n (sync active-low); i_if_pc -> o_pred_taken/o_pred_target;
//        i_ex_* resolution inputs -> o_ex_taken/o_mispredict/o_redirect_pc;
//        o_branch_cnt/o_miss_cnt saturating statistics.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [PC_W-1:0]   i_if_pc,
  output logic              o_pred_taken,
  output logic [PC_W-1:0]   o_pred_target,
  input  logic              i_ex_valid,
  input  logic [2:0]        i_ex_branch,
  input  logic [1:0]        i_ex_relation,
  input  logic [PC_W-1:0]   i_ex_pc,
  input  logic [PC_W-1:0]   i_ex_target,
  input  logic              i_ex_pred_taken,
  output logic              o_ex_taken,
  output logic              o_mispredict,
  output logic [PC_W-1:0]   o_redirect_pc,
  output logic [STAT_W-1:0] o_branch_cnt,
  output logic [STAT_W-1:0] o_miss_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(cnt_weak_taken(CNT_W));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_weak_not_taken(CNT_W));

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [CNT_W-1:0] cnt_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [STAT_W-1:0] branch_cnt_q;
  logic [STAT_W-1:0] miss_cnt_q;

  // Word-aligned PCs: the low two bits never select an entry.
  logic             unused_pc_lsbs;
  assign unused_pc_lsbs = ^{i_if_pc[1:0], i_ex_pc[1:0]};

  // ---------------- IF lookup ----------------
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;

  assign if_idx = i_if_pc[IDX_W+1:2];
  assign if_tag = i_if_pc[PC_W-1:IDX_W+2];
  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

  // Reads the registered array, so a same-cycle update to this index is not visible yet.
  assign o_pred_taken  = if_hit && cnt_q[if_idx][CNT_W-1];
  assign o_pred_target = if_hit ? target_q[if_idx] : '0;

  // ---------------- EX resolution ----------------
  logic is_br;

  branch_resolve u_resolve (
    .i_br    (i_ex_branch),
    .i_rel   (i_ex_relation),
    .o_taken (o_ex_taken)
  );

  assign is_br = i_ex_valid && (i_ex_branch != BR_NONE) && (i_ex_branch != BR_RSVD);

  // A non-branch carrying a stale taken prediction is not flushed here; the
  // wrong-path fetch has already been squashed by decode.
  assign o_mispredict  = is_br && (o_ex_taken != i_ex_pred_taken);
  assign o_redirect_pc = o_ex_taken ? i_ex_target : (i_ex_pc + PC_W'(4));

  // ---------------- Training ----------------
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_same;
  logic [CNT_W-1:0] ex_cnt_cur;
  logic [CNT_W-1:0] ex_cnt_nxt;

  assign ex_idx     = i_ex_pc[IDX_W+1:2];
  assign ex_tag     = i_ex_pc[PC_W-1:IDX_W+2];
  assign ex_same    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign ex_cnt_cur = cnt_q[ex_idx];

  // A newly allocated entry starts at the weak state on the side of the outcome;
  // an existing entry steps one toward the outcome and saturates.
  always_comb begin
    ex_cnt_nxt = ex_cnt_cur;
    if (!ex_same) begin
      ex_cnt_nxt = o_ex_taken ? CNT_WT : CNT_WNT;
    end else if (o_ex_taken) begin
      if (ex_cnt_cur != '1) ex_cnt_nxt = ex_cnt_cur + 1'b1;
    end else begin
      if (ex_cnt_cur != '0) ex_cnt_nxt = ex_cnt_cur - 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        cnt_q[i]    <= CNT_WNT;
        target_q[i] <= '0;
      end
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (is_br) begin
        valid_q[ex_idx] <= 1'b1;
        tag_q[ex_idx]   <= ex_tag;
        cnt_q[ex_idx]   <= ex_cnt_nxt;
        if (o_ex_taken) target_q[ex_idx] <= i_ex_target;
        if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
      end
      if (o_mispredict && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  assign o_branch_cnt = branch_cnt_q;
  assign o_miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with default parameters (64 entries, 2-bit counters).
// Inputs change 1 time unit after the rising edge; outputs are checked mid-cycle.
// Table index = pc[7:2], tag = pc[31:8].
module tb_branch_predict_unit;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_if_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_ex_valid;
  logic [2:0]  i_ex_branch;
  logic [1:0]  i_ex_relation;
  logic [31:0] i_ex_pc;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic        o_ex_taken;
  logic        o_mispredict;
  logic [31:0] o_redirect_pc;
  logic [31:0] o_branch_cnt;
  logic [31:0] o_miss_cnt;

  int checks = 0;
  int errors = 0;

  branch_predict_unit dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_if_pc         (i_if_pc),
    .o_pred_taken    (o_pred_taken),
    .o_pred_target   (o_pred_target),
    .i_ex_valid      (i_ex_valid),
    .i_ex_branch     (i_ex_branch),
    .i_ex_relation   (i_ex_relation),
    .i_ex_pc         (i_ex_pc),
    .i_ex_target     (i_ex_target),
    .i_ex_pred_taken (i_ex_pred_taken),
    .o_ex_taken      (o_ex_taken),
    .o_mispredict    (o_mispredict),
    .o_redirect_pc   (o_redirect_pc),
    .o_branch_cnt    (o_branch_cnt),
    .o_miss_cnt      (o_miss_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs may change right after it.
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Present an EX-stage branch; outputs settle before the mid-cycle checks.
  task automatic ex(input logic v, input logic [2:0] br, input logic [1:0] rel,
                    input logic [31:0] pc, input logic [31:0] tgt, input logic pred);
    i_ex_valid      = v;
    i_ex_branch     = br;
    i_ex_relation   = rel;
    i_ex_pc         = pc;
    i_ex_target     = tgt;
    i_ex_pred_taken = pred;
    #2;
  endtask

  task automatic look(input logic [31:0] pc);
    i_if_pc = pc;
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_if_pc = 32'h0;
    ex(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b0);
    step();
    step();
    i_rst_n = 1'b1;

    // Reset state
    look(32'h0040_0010);
    chk("rst_pred_taken",  {31'd0, o_pred_taken}, 32'd0);
    chk("rst_pred_target", o_pred_target, 32'h0);
    chk("rst_branch_cnt",  o_branch_cnt, 32'd0);
    chk("rst_miss_cnt",    o_miss_cnt, 32'd0);

    // beq taken, predicted not-taken -> mispredict, entry allocated weakly-taken
    ex(1'b1, 3'b001, 2'b01, 32'h0040_0010, 32'h0040_0100, 1'b0);
    chk("beq_taken",      {31'd0, o_ex_taken}, 32'd1);
    chk("beq_mispredict", {31'd0, o_mispredict}, 32'd1);
    chk("beq_redirect",   o_redirect_pc, 32'h0040_0100);
    chk("beq_same_cycle_old", {31'd0, o_pred_taken}, 32'd0);
    step();
    ex(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b0);
    look(32'h0040_0010);
    chk("beq_pred_taken",  {31'd0, o_pred_taken}, 32'd1);
    chk("beq_pred_target", o_pred_target, 32'h0040_0100);
    chk("beq_miss_cnt",    o_miss_cnt, 32'd1);
    chk("beq_branch_cnt",  o_branch_cnt, 32'd1);

    // bne at 0x0040_0020: not-taken x3 (01 -> 00 -> 00), then taken (-> 01)
    look(32'h0040_0020);
    ex(1'b1, 3'b010, 2'b01, 32'h0040_0020, 32'h0040_0200, 1'b0);
    chk("bne_nt1_taken",    {31'd0, o_ex_taken}, 32'd0);
    chk("bne_nt1_mispred",  {31'd0, o_mispredict}, 32'd0);
    chk("bne_nt1_redirect", o_redirect_pc, 32'h0040_0024);
    step();
    look(32'h0040_0020);
    chk("bne_after_nt1_pred", {31'd0, o_pred_taken}, 32'd0);
    step();
    look(32'h0040_0020);
    chk("bne_after_nt2_pred", {31'd0, o_pred_taken}, 32'd0);
    step();
    look(32'h0040_0020);
    chk("bne_after_nt3_pred", {31'd0, o_pred_taken}, 32'd0);
    ex(1'b1, 3'b010, 2'b00, 32'h0040_0020, 32'h0040_0200, 1'b0);
    chk("bne_t_taken",    {31'd0, o_ex_taken}, 32'd1);
    chk("bne_t_mispred",  {31'd0, o_mispredict}, 32'd1);
    chk("bne_t_redirect", o_redirect_pc, 32'h0040_0200);
    step();
    ex(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b0);
    look(32'h0040_0020);
    chk("bne_after_t_pred", {31'd0, o_pred_taken}, 32'd0);
    chk("bne_branch_cnt",   o_branch_cnt, 32'd5);
    chk("bne_miss_cnt",     o_miss_cnt, 32'd2);

    // Alias: 0x0040_0110 shares index 4 with 0x0040_0010
    look(32'h0040_0110);
    chk("alias_miss_pred",   {31'd0, o_pred_taken}, 32'd0);
    chk("alias_miss_target", o_pred_target, 32'h0);
    ex(1'b1, 3'b001, 2'b01, 32'h0040_0110, 32'h0040_0300, 1'b0);
    chk("alias_same_cycle_old", {31'd0, o_pred_taken}, 32'd0);
    step();
    ex(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b0);
    look(32'h0040_0110);
    chk("alias_new_pred",   {31'd0, o_pred_taken}, 32'd1);
    chk("alias_new_target", o_pred_target, 32'h0040_0300);
    look(32'h0040_0010);
    chk("alias_evicted_pred",   {31'd0, o_pred_taken}, 32'd0);
    chk("alias_evicted_target", o_pred_target, 32'h0);

    // bgez at 0x0040_0040 (index 16)
    look(32'h0040_0040);
    ex(1'b1, 3'b110, 2'b10, 32'h0040_0040, 32'h0040_0400, 1'b1);
    chk("bgez_gt_taken",    {31'd0, o_ex_taken}, 32'd1);
    chk("bgez_gt_mispred",  {31'd0, o_mispredict}, 32'd0);
    chk("bgez_gt_redirect", o_redirect_pc, 32'h0040_0400);
    step();
    look(32'h0040_0040);
    chk("bgez_pred_taken",  {31'd0, o_pred_taken}, 32'd1);
    chk("bgez_pred_target", o_pred_target, 32'h0040_0400);
    ex(1'b1, 3'b110, 2'b00, 32'h0040_0040, 32'h0040_0400, 1'b1);
    chk("bgez_lt_taken",    {31'd0, o_ex_taken}, 32'd0);
    chk("bgez_lt_mispred",  {31'd0, o_mispredict}, 32'd1);
    chk("bgez_lt_redirect", o_redirect_pc, 32'h0040_0044);
    chk("bgez_same_cycle_old", {31'd0, o_pred_taken}, 32'd1);
    step();
    ex(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b0);
    look(32'h0040_0040);
    chk("bgez_after_nt_pred", {31'd0, o_pred_taken}, 32'd0);

    // Illegal relation: blez with rel=11 resolves taken
    ex(1'b1, 3'b011, 2'b11, 32'h0040_0080, 32'h0040_0800, 1'b1);
    chk("blez_rel11_taken",   {31'd0, o_ex_taken}, 32'd1);
    chk("blez_rel11_mispred", {31'd0, o_mispredict}, 32'd0);
    step();
    ex(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_branch_cnt", o_branch_cnt, 32'd9);
    chk("pre_rst_miss_cnt",   o_miss_cnt, 32'd4);

    // Stale alias: non-branch with predicted-taken does not flush or count
    ex(1'b1, 3'b000, 2'b01, 32'h0040_0110, 32'h0040_0900, 1'b1);
    chk("nonbr_mispred", {31'd0, o_mispredict}, 32'd0);
    step();
    ex(1'b0, 3'b000, 2'b00, 32'h0, 32'h0, 1'b0);
    look(32'h0040_0110);
    chk("nonbr_branch_cnt", o_branch_cnt, 32'd9);
    chk("nonbr_entry_kept", o_pred_target, 32'h0040_0300);

    // Reset coinciding with a mispredicting update: reset wins
    i_rst_n = 1'b0;
    ex(1'b1, 3'b001, 2'b01, 32'h0040_0010, 32'h0040_0100, 1'b0);
    step();
    i_rst_n = 1'b1;
    ex(1'b0, 3'b001, 2'b01, 32'h0040_0010, 32'h0040_0100, 1'b0);
    look(32'h0040_0010);
    chk("post_rst_pred_a",   {31'd0, o_pred_taken}, 32'd0);
    chk("post_rst_target_a", o_pred_target, 32'h0);
    look(32'h0040_0110);
    chk("post_rst_pred_b",   {31'd0, o_pred_taken}, 32'd0);
    look(32'h0040_0040);
    chk("post_rst_target_c", o_pred_target, 32'h0);
    chk("post_rst_branch_cnt", o_branch_cnt, 32'd0);
    chk("post_rst_miss_cnt",   o_miss_cnt, 32'd0);
    chk("invalid_beq_mispred", {31'd0, o_mispredict}, 32'd0);
    step();
    look(32'h0040_0010);
    chk("invalid_beq_branch_cnt", o_branch_cnt, 32'd0);
    chk("invalid_beq_miss_cnt",   o_miss_cnt, 32'd0);
    chk("invalid_beq_no_train",   {31'd0, o_pred_taken}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
